sd_host_cmd: RTL
================

Name: sd_host_cmd

Overview:
SD-bus host-side command initiator. It is the counterpart of the card-side `device` command responder. It generates SD_CLK, serialises a 48-bit command frame with CRC7 onto CMD, then optionally receives and checks the 48-bit or 136-bit response. It sits between the host AXI register block (start/argument/response registers) and the SD pins; the CMD pin is open-drain style with an external pull-up.

Parameters:
CLK_DIV_HALF, 4, clk cycles per SD_CLK half-period (≥2); default gives SD_CLK = clk/8
NCR_MAX, 64, SD_CLK cycles allowed between command end bit and response start bit before timeout
NRC_GAP, 8, SD_CLK cycles CMD stays released/idle after a transaction before done

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  1-clk pulse; accepted only when busy=0
cmd_index  in  6  command index, sampled on accepted start
cmd_arg  in  32  argument, sampled on accepted start
resp_type  in  2  0 none, 1 R1/R6/R7 (48b, CRC+index check), 2 R2 (136b), 3 R3 (48b, no CRC/index check)
busy  out  1  transaction in progress
done  out  1  1-clk pulse at end of transaction
resp  out  128  response payload (see Behaviour), valid from done until next accepted start
crc_err  out  1  response CRC7 mismatch; valid with done
index_err  out  1  response index ≠ cmd_index (resp_type 1 only); valid with done
timeout  out  1  no response start bit within NCR_MAX; valid with done
sd_clk_o  out  1  SD clock
sd_cmd_i  in  1  CMD pin input
sd_cmd_o  out  1  CMD drive value
sd_cmd_t  out  1  1 = CMD tristated

Behaviour:
- Reset: sd_clk_o=0, sd_cmd_o=1, sd_cmd_t=1, busy=0, done=0, resp=0, crc_err=index_err=timeout=0, FSM=IDLE. A reset mid-transaction aborts immediately with the same values and no done pulse.
- SD_CLK is free-running: it toggles every CLK_DIV_HALF clk cycles. A "fall event" is the clk cycle in which sd_clk_o goes 1→0; a "rise event" is the cycle in which it goes 0→1.
- Frame: {0, 1, cmd_index[5:0], cmd_arg[31:0], crc7[6:0], 1}. crc7 uses polynomial x^7+x^3+1, initialised to 0, and covers the first 40 bits MSB-first.
- IDLE: when start=1, latch inputs, set busy=1 in the next cycle, go to TX. A start while busy is ignored.
- TX: on each fall event, drive the next bit MSB-first with sd_cmd_t=0. The first fall event after start drives the start bit. After the end bit has been held one full SD_CLK period (next fall event), set sd_cmd_t=1 and sd_cmd_o=1. Then go to GAP if resp_type=0, otherwise to WAIT.
- WAIT: on each rise event, sample sd_cmd_i. If 0, this is the start bit: go to RX with bit count 1. If NCR_MAX rise events elapse without a 0, set timeout=1 and go to GAP.
- RX: shift sd_cmd_i in on each rise event until 48 bits (types 1/3) or 136 bits (type 2) are received, then go to GAP.
- Response mapping:
  - 48b: resp[127:38]=0, resp[37:32]=bits[45:40] (index), resp[31:0]=bits[39:8].
  - 136b: resp[127:0]=bits[127:0] of the frame, so resp[7:1] is the embedded CRC and resp[0] the end bit.
- Checks:
  - Type 1: crc_err when CRC7 over frame bits[47:8] ≠ bits[7:1]; index_err when bits[45:40] ≠ latched cmd_index.
  - Type 2: crc_err when CRC7 over frame bits[127:8] ≠ bits[7:1].
  - Type 3: no CRC or index checks.
  - Any type: an end bit of 0 also sets crc_err.
- GAP: wait NRC_GAP rise events with CMD released, then pulse done for 1 clk, clear busy in the same cycle, return to IDLE. The flags and resp hold until the next accepted start, which clears them.
- start asserted in the same cycle as done is ignored; the bench must wait for busy=0.

Test Plan:
- CMD0, arg 0, resp_type 0 → CMD line carries 0x400000000095 on successive fall events; sd_cmd_t=0 for exactly 48 SD_CLK periods; done pulses after NRC_GAP; no flags set.
- CMD8, arg 0x000001AA, type 1; bench card replies 0x08000001AA13 three SD_CLK periods after end bit → frame sent is 0x48000001AA87; resp[37:0]=0x08000001AA; crc_err=index_err=timeout=0.
- Same as above but reply CRC byte 0x15 → crc_err=1. Reply index 0x09 (0x09000001AA + valid CRC) → index_err=1, crc_err=0.
- CMD17, arg 0, type 1, CMD held high → frame 0x510000000055; timeout=1 after exactly NCR_MAX rise events; resp=0.
- CMD2, type 2; bench replies with 0x3F, then a 120-bit CID, then valid CRC7 and end bit → resp[127:8]=CID, crc_err=0. Flip one CID bit → crc_err=1.
- Assert reset during RX bit 20 → next cycle busy=0, sd_cmd_t=1, sd_clk_o=0, no done pulse. A new CMD0 afterwards completes normally.

Source files
------------

// File: rtl/sd_host_cmd.sv
// SD-bus host command initiator: free-running SD_CLK, CRC7-protected 48-bit
// command frame out on CMD, optional 48/136-bit response capture and checking.
module sd_host_cmd #(
  parameter int CLK_DIV_HALF = 4,
  parameter int NCR_MAX      = 64,
  parameter int NRC_GAP      = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   cmd_index,
  input  logic [31:0]  cmd_arg,
  input  logic [1:0]   resp_type,
  output logic         busy,
  output logic         done,
  output logic [127:0] resp,
  output logic         crc_err,
  output logic         index_err,
  output logic         timeout,
  output logic         sd_clk_o,
  input  logic         sd_cmd_i,
  output logic         sd_cmd_o,
  output logic         sd_cmd_t
);

  localparam int DW = $clog2(CLK_DIV_HALF + 1);
  localparam int CW = 16;

  typedef enum logic [2:0] {S_IDLE, S_TX, S_WAIT, S_RX, S_GAP} state_t;
  state_t state, state_n;

  // CRC7 (x^7+x^3+1, init 0). Leading zero bits leave a zero register
  // unchanged, so shorter fields are simply zero-extended to 120 bits.
  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 119; i >= 0; i--) begin
      if (d[i] ^ c[6]) c = {c[5:0], 1'b0} ^ 7'h09;
      else             c = {c[5:0], 1'b0};
    end
    return c;
  endfunction

  logic [DW-1:0]  div_cnt;
  logic           tick, fall_evt, rise_evt;
  logic [5:0]     idx_q;
  logic [1:0]     rt_q;
  logic [47:0]    frame_q;
  logic [7:0]     bit_cnt;
  logic [CW-1:0]  wait_cnt;
  logic [126:0]   rx_sr;
  logic [127:0]   rx_next;
  logic           rx_last, accept;
  logic [127:0]   resp_calc;
  logic           crc_bad, idx_bad;

  assign tick     = (div_cnt == DW'(CLK_DIV_HALF - 1));
  assign fall_evt = tick & sd_clk_o;
  assign rise_evt = tick & ~sd_clk_o;
  assign accept   = (state == S_IDLE) && start && !done;
  assign rx_next  = {rx_sr, sd_cmd_i};
  assign rx_last  = (bit_cnt == ((rt_q == 2'd2) ? 8'd135 : 8'd47));

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt  <= '0;
      sd_clk_o <= 1'b0;
    end else if (tick) begin
      div_cnt  <= '0;
      sd_clk_o <= ~sd_clk_o;
    end else begin
      div_cnt  <= div_cnt + 1'b1;
    end
  end

  // Response mapping and checks on the frame including the bit arriving now.
  always_comb begin
    resp_calc = '0;
    crc_bad   = ~rx_next[0];
    idx_bad   = 1'b0;
    if (rt_q == 2'd2) begin
      resp_calc = rx_next;
      if (crc7(rx_next[127:8]) != rx_next[7:1]) crc_bad = 1'b1;
    end else begin
      resp_calc = {90'b0, rx_next[45:40], rx_next[39:8]};
      if (rt_q == 2'd1) begin
        if (crc7({80'b0, rx_next[47:8]}) != rx_next[7:1]) crc_bad = 1'b1;
        idx_bad = (rx_next[45:40] != idx_q);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE: if (accept) state_n = S_TX;
      S_TX:   if (fall_evt && bit_cnt == 8'd48)
                state_n = (rt_q == 2'd0) ? S_GAP : S_WAIT;
      S_WAIT: if (rise_evt) begin
                if (!sd_cmd_i)                           state_n = S_RX;
                else if (wait_cnt == CW'(NCR_MAX - 1))   state_n = S_GAP;
              end
      S_RX:   if (rise_evt && rx_last) state_n = S_GAP;
      S_GAP:  if (rise_evt && wait_cnt == CW'(NRC_GAP - 1)) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      resp      <= '0;
      crc_err   <= 1'b0;
      index_err <= 1'b0;
      timeout   <= 1'b0;
      sd_cmd_o  <= 1'b1;
      sd_cmd_t  <= 1'b1;
      idx_q     <= '0;
      rt_q      <= '0;
      frame_q   <= '0;
      bit_cnt   <= '0;
      wait_cnt  <= '0;
      rx_sr     <= '0;
    end else begin
      done <= 1'b0;
      if (state_n != state) wait_cnt <= '0;
      else if (rise_evt)    wait_cnt <= wait_cnt + 1'b1;

      case (state)
        S_IDLE: if (accept) begin
          idx_q     <= cmd_index;
          rt_q      <= resp_type;
          frame_q   <= {2'b01, cmd_index, cmd_arg,
                        crc7({80'b0, 2'b01, cmd_index, cmd_arg}), 1'b1};
          busy      <= 1'b1;
          resp      <= '0;
          crc_err   <= 1'b0;
          index_err <= 1'b0;
          timeout   <= 1'b0;
          bit_cnt   <= '0;
          rx_sr     <= '0;
        end
        S_TX: if (fall_evt) begin
          if (bit_cnt == 8'd48) begin
            sd_cmd_t <= 1'b1;
            sd_cmd_o <= 1'b1;
          end else begin
            sd_cmd_o <= frame_q[47];
            sd_cmd_t <= 1'b0;
            frame_q  <= {frame_q[46:0], 1'b0};
            bit_cnt  <= bit_cnt + 1'b1;
          end
        end
        S_WAIT: if (rise_evt) begin
          // The start bit is implied by the count; it never needs storing.
          if (!sd_cmd_i)                          bit_cnt <= 8'd1;
          else if (wait_cnt == CW'(NCR_MAX - 1))  timeout <= 1'b1;
        end
        S_RX: if (rise_evt) begin
          rx_sr   <= rx_next[126:0];
          bit_cnt <= bit_cnt + 1'b1;
          if (rx_last) begin
            resp      <= resp_calc;
            crc_err   <= crc_bad;
            index_err <= idx_bad;
          end
        end
        S_GAP: if (rise_evt && wait_cnt == CW'(NRC_GAP - 1)) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
